sensor_scan_ctrl: RTL

Sequencer that polls the four level sensors one at a time over a shared sensor bus (select/request/acknowledge) and captures each 8-bit reading. Once all four slots are filled it presents them as one frame to the downstream averaging block (sensor1..sensor4 inputs) using a valid/ready handshake. A sensor that does not answer within a timeout is recorded as 0, which the averager already treats as a faulty sensor.

---
 rtl/sensor_scan_ctrl_if.sv | 25 ++
 rtl/sensor_scan_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/sensor_scan_ctrl_if.sv
// Shared sensor bus plus the frame handshake toward the averaging block.
// master = scan controller, slave = sensors/averager side.
interface sensor_scan_ctrl_if;
    logic [1:0] sens_sel;
    logic       sens_req;
    logic       sens_ack;
    logic [7:0] sens_data;
    logic [7:0] s1_out;
    logic [7:0] s2_out;
    logic [7:0] s3_out;
    logic [7:0] s4_out;
    logic [3:0] fault;
    logic       frame_valid;
    logic       frame_ready;

    modport master (
        output sens_sel, sens_req, s1_out, s2_out, s3_out, s4_out, fault, frame_valid,
        input  sens_ack, sens_data, frame_ready
    );

    modport slave (
        input  sens_sel, sens_req, s1_out, s2_out, s3_out, s4_out, fault, frame_valid,
        output sens_ack, sens_data, frame_ready
    );
endinterface

// File: rtl/sensor_scan_ctrl.sv
// Polls four level sensors in turn, captures one 8-bit reading each, and hands
// the frame downstream over valid/ready. Optional macro SENSOR_AUTOSCAN_EN adds periodic self-triggering.
module sensor_scan_ctrl #(
    parameter int TIMEOUT     = 16,
    parameter int SCAN_PERIOD = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    sensor_scan_ctrl_if.master  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       idx;
    logic [7:0]       cnt;
    logic [3:0][7:0]  slots;
    logic [3:0]       fault_r;
    logic             trig;
    logic             slot_end;

`ifdef SENSOR_AUTOSCAN_EN
    localparam int PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    logic [PW-1:0] period_cnt;
    logic          wrap;

    assign wrap = (period_cnt == PW'(SCAN_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            period_cnt <= '0;
        else if (wrap)
            period_cnt <= '0;
        else
            period_cnt <= period_cnt + 1'b1;
    end

    assign trig = start | wrap;
`else
    assign trig = start;
`endif

    // An ack on the final allowed cycle still counts as a valid reading.
    assign slot_end = bus.sens_ack || (cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= 2'd0;
            cnt     <= 8'd0;
            slots   <= '0;
            fault_r <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        state   <= REQ;
                        idx     <= 2'd0;
                        fault_r <= 4'd0;
                    end
                end
                REQ: begin
                    cnt   <= 8'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (slot_end) begin
                        slots[idx] <= bus.sens_ack ? bus.sens_data : 8'd0;
                        if (!bus.sens_ack)
                            fault_r[idx] <= 1'b1;
                        if (idx == 2'd3) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= REQ;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (bus.frame_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy            = (state != IDLE);
    assign bus.sens_sel    = idx;
    assign bus.sens_req    = (state == REQ);
    assign bus.frame_valid = (state == DONE);
    assign bus.fault       = fault_r;
    assign bus.s1_out      = slots[0];
    assign bus.s2_out      = slots[1];
    assign bus.s3_out      = slots[2];
    assign bus.s4_out      = slots[3];
endmodule
